// File: rtl/softreg_resp_router_if.sv
// Soft-register response router bus: request observation, app response input,
// per-source response outputs and status.
interface softreg_resp_router_if #(
    parameter int LOG_DEPTH = 6,
    parameter int DATA_W    = 64
);
    logic              req_valid;
    logic              req_isWrite;
    logic              req_src;
    logic              app_resp_valid;
    logic [DATA_W-1:0] app_resp_data;
    logic              err_clr;

    logic              int_resp_valid;
    logic [DATA_W-1:0] int_resp_data;
    logic              host_resp_valid;
    logic [DATA_W-1:0] host_resp_data;
    logic [LOG_DEPTH:0] outstanding;
    logic              err_overflow;
    logic [15:0]       timeout_cnt;
    logic [15:0]       spurious_cnt;

    modport master (
        output req_valid, req_isWrite, req_src, app_resp_valid, app_resp_data, err_clr,
        input  int_resp_valid, int_resp_data, host_resp_valid, host_resp_data,
               outstanding, err_overflow, timeout_cnt, spurious_cnt
    );

    modport slave (
        input  req_valid, req_isWrite, req_src, app_resp_valid, app_resp_data, err_clr,
        output int_resp_valid, int_resp_data, host_resp_valid, host_resp_data,
               outstanding, err_overflow, timeout_cnt, spurious_cnt
    );
endinterface

// File: rtl/softreg_resp_router.sv
// Routes in-order soft-register read responses back to the issuing source using
// a tag FIFO; synthesizes timeout responses and reports spurious/overflow events.
module softreg_resp_router #(
    parameter int              LOG_DEPTH = 6,
    parameter int              DATA_W    = 64,
    parameter int              TIMEOUT   = 1024,
    parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(64'hDEAD_BEEF_DEAD_BEEF)
) (
    input logic clk,
    input logic rst_n,
    softreg_resp_router_if.slave bus
);
    localparam int DEPTH = 1 << LOG_DEPTH;
    localparam int PW    = LOG_DEPTH + 1;
    localparam int TW    = $clog2(TIMEOUT + 1);

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (&v) ? v : v + 16'd1;
    endfunction

    function automatic logic [PW-1:0] sat_inc_skip(input logic [PW-1:0] v);
        return (&v) ? v : v + PW'(1);
    endfunction

    logic [DEPTH-1:0]  tags_q;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     outst_q, outst_d;
    logic [PW-1:0]     skip_q, skip_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic              int_v_q, int_v_d;
    logic              host_v_q, host_v_d;
    logic [DATA_W-1:0] int_data_q, int_data_d;
    logic [DATA_W-1:0] host_data_q, host_data_d;
    logic              ovf_q, ovf_d;
    logic [15:0]       tcnt_q, tcnt_d;
    logic [15:0]       scnt_q, scnt_d;

    logic              empty, full, head_tag;
    logic              push_req, push_ok, overflow;
    logic              skip_dec, real_pop, spurious, tmo, pop;
    logic [DATA_W-1:0] resp_data;

    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                   (wr_ptr_q[LOG_DEPTH-1:0] == rd_ptr_q[LOG_DEPTH-1:0]);
        head_tag = tags_q[rd_ptr_q[LOG_DEPTH-1:0]];
        push_req = bus.req_valid && !bus.req_isWrite;

        // Late responses owed by timed-out reads are swallowed before anything else.
        skip_dec = bus.app_resp_valid && (skip_q != '0);
        real_pop = bus.app_resp_valid && !skip_dec && !empty;
        spurious = bus.app_resp_valid && !skip_dec && empty;
        tmo      = !empty && !real_pop && (timer_q == TW'(TIMEOUT));
        pop      = real_pop || tmo;
        push_ok  = push_req && (!full || pop);
        overflow = push_req && full && !pop;

        wr_ptr_d = wr_ptr_q + PW'(push_ok);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        outst_d  = outst_q + PW'(push_ok) - PW'(pop);
        timer_d  = (pop || empty) ? '0 : timer_q + TW'(1);

        case ({tmo, skip_dec})
            2'b10:   skip_d = sat_inc_skip(skip_q);
            2'b01:   skip_d = skip_q - PW'(1);
            default: skip_d = skip_q;
        endcase

        resp_data   = real_pop ? bus.app_resp_data : ERR_DATA;
        int_v_d     = pop && !head_tag;
        host_v_d    = pop && head_tag;
        int_data_d  = int_v_d  ? resp_data : '0;
        host_data_d = host_v_d ? resp_data : '0;

        // Clear wins over any same-cycle status event.
        ovf_d  = bus.err_clr ? 1'b0  : (ovf_q || overflow);
        tcnt_d = bus.err_clr ? 16'd0 : (tmo      ? sat_inc16(tcnt_q) : tcnt_q);
        scnt_d = bus.err_clr ? 16'd0 : (spurious ? sat_inc16(scnt_q) : scnt_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            outst_q     <= '0;
            skip_q      <= '0;
            timer_q     <= '0;
            int_v_q     <= 1'b0;
            host_v_q    <= 1'b0;
            int_data_q  <= '0;
            host_data_q <= '0;
            ovf_q       <= 1'b0;
            tcnt_q      <= '0;
            scnt_q      <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            outst_q     <= outst_d;
            skip_q      <= skip_d;
            timer_q     <= timer_d;
            int_v_q     <= int_v_d;
            host_v_q    <= host_v_d;
            int_data_q  <= int_data_d;
            host_data_q <= host_data_d;
            ovf_q       <= ovf_d;
            tcnt_q      <= tcnt_d;
            scnt_q      <= scnt_d;
        end
    end

    // Tag storage is pure data; pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push_ok) tags_q[wr_ptr_q[LOG_DEPTH-1:0]] <= bus.req_src;
    end

    assign bus.int_resp_valid  = int_v_q;
    assign bus.int_resp_data   = int_data_q;
    assign bus.host_resp_valid = host_v_q;
    assign bus.host_resp_data  = host_data_q;
    assign bus.outstanding     = outst_q;
    assign bus.err_overflow    = ovf_q;
    assign bus.timeout_cnt     = tcnt_q;
    assign bus.spurious_cnt    = scnt_q;
endmodule

// File: tb/tb_softreg_resp_router.sv
// Bench for softreg_resp_router: vector table, directed corner sequences and a
// randomized run against a queue/timestamp reference model.
module tb_softreg_resp_router;
    localparam int LD    = 2;
    localparam int DEPTH = 1 << LD;
    localparam int TMO   = 8;
    localparam int SKIP_MAX = (1 << (LD + 1)) - 1;
    localparam logic [63:0] ERR = 64'hDEAD_BEEF_DEAD_BEEF;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    softreg_resp_router_if #(.LOG_DEPTH(LD), .DATA_W(64)) bus ();

    softreg_resp_router #(.LOG_DEPTH(LD), .DATA_W(64), .TIMEOUT(TMO), .ERR_DATA(ERR)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: queue of source tags plus the cycle index at which the head arrived.
    bit          mq[$];
    int          m_skip, m_tc, m_sc, m_hs, mc;
    bit          m_ovf, mdl_on;
    bit          e_iv, e_hv;
    logic [63:0] e_id, e_hd;

    function automatic void model_reset();
        mq.delete();
        m_skip = 0; m_tc = 0; m_sc = 0; m_hs = 0; mc = 0; m_ovf = 0;
        e_iv = 0; e_hv = 0; e_id = '0; e_hd = '0;
    endfunction

    function automatic void model_step();
        bit was_empty, real_p, tmo_p, popped, ptag;
        logic [63:0] pdata;
        e_iv = 0; e_hv = 0; e_id = '0; e_hd = '0;
        was_empty = (mq.size() == 0);
        real_p = 0; tmo_p = 0;
        if (bus.app_resp_valid) begin
            if (m_skip > 0) m_skip--;
            else if (!was_empty) real_p = 1;
            else if (m_sc < 65535) m_sc++;
        end
        if (!real_p && !was_empty && (mc - m_hs == TMO)) begin
            tmo_p = 1;
            if (m_tc < 65535) m_tc++;
            if (m_skip < SKIP_MAX) m_skip++;
        end
        popped = real_p || tmo_p;
        if (popped) begin
            ptag  = mq.pop_front();
            pdata = real_p ? bus.app_resp_data : ERR;
            if (ptag) begin e_hv = 1; e_hd = pdata; end
            else      begin e_iv = 1; e_id = pdata; end
        end
        if (bus.req_valid && !bus.req_isWrite) begin
            if (mq.size() < DEPTH) mq.push_back(bus.req_src);
            else m_ovf = 1;
        end
        if ((popped || was_empty) && mq.size() > 0) m_hs = mc + 1;
        if (bus.err_clr) begin m_ovf = 0; m_tc = 0; m_sc = 0; end
        mc++;
    endfunction

    task automatic drive(bit rv, bit w, bit s, bit av, logic [63:0] d, bit clr);
        bus.req_valid = rv; bus.req_isWrite = w; bus.req_src = s;
        bus.app_resp_valid = av; bus.app_resp_data = d; bus.err_clr = clr;
    endtask

    task automatic step(bit rv, bit w, bit s, bit av, logic [63:0] d, bit clr);
        drive(rv, w, s, av, d, clr);
        if (mdl_on) model_step();
        @(posedge clk);
        #1;
        if (mdl_on) begin
            chk("rnd int_valid",  bus.int_resp_valid, e_iv);
            chk("rnd int_data",   bus.int_resp_data,  e_id);
            chk("rnd host_valid", bus.host_resp_valid, e_hv);
            chk("rnd host_data",  bus.host_resp_data,  e_hd);
            chk("rnd outstanding", bus.outstanding, mq.size());
            chk("rnd overflow", bus.err_overflow, m_ovf);
            chk("rnd timeout_cnt", bus.timeout_cnt, m_tc);
            chk("rnd spurious_cnt", bus.spurious_cnt, m_sc);
        end
    endtask

    task automatic reset_dut();
        drive(0, 0, 0, 0, '0, 0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit rv, w, s, av;
        logic [63:0] d;
        bit iv;
        logic [63:0] id;
        bit hv;
        logic [63:0] hd;
        int out;
        int sc;
    } vec_t;

    function automatic vec_t mkv(bit rv, bit w, bit s, bit av, logic [63:0] d,
                                 bit iv, logic [63:0] id, bit hv, logic [63:0] hd,
                                 int out, int sc);
        vec_t v;
        v.rv = rv; v.w = w; v.s = s; v.av = av; v.d = d;
        v.iv = iv; v.id = id; v.hv = hv; v.hd = hd; v.out = out; v.sc = sc;
        return v;
    endfunction

    vec_t tbl[14];

    initial begin
        int k;
        bit seen;
        logic [63:0] hd;
        mdl_on = 0;
        model_reset();

        tbl[0]  = mkv(1,0,0,0,0,  0,0, 0,0, 1,0);
        tbl[1]  = mkv(1,0,1,0,0,  0,0, 0,0, 2,0);
        tbl[2]  = mkv(1,0,1,0,0,  0,0, 0,0, 3,0);
        tbl[3]  = mkv(1,0,0,0,0,  0,0, 0,0, 4,0);
        tbl[4]  = mkv(0,0,0,1,1,  1,1, 0,0, 3,0);
        tbl[5]  = mkv(0,0,0,1,2,  0,0, 1,2, 2,0);
        tbl[6]  = mkv(0,0,0,1,3,  0,0, 1,3, 1,0);
        tbl[7]  = mkv(0,0,0,1,4,  1,4, 0,0, 0,0);
        tbl[8]  = mkv(0,0,0,0,0,  0,0, 0,0, 0,0);
        tbl[9]  = mkv(1,1,1,0,0,  0,0, 0,0, 0,0);
        tbl[10] = mkv(1,1,1,0,0,  0,0, 0,0, 0,0);
        tbl[11] = mkv(1,1,1,0,0,  0,0, 0,0, 0,0);
        tbl[12] = mkv(0,0,0,1,5,  0,0, 0,0, 0,1);
        tbl[13] = mkv(0,0,0,0,0,  0,0, 0,0, 0,1);

        // Reset state
        drive(0, 0, 0, 0, '0, 0);
        #2;
        chk("reset int_valid",  bus.int_resp_valid, 0);
        chk("reset host_valid", bus.host_resp_valid, 0);
        chk("reset outstanding", bus.outstanding, 0);
        chk("reset status", {bus.err_overflow, bus.timeout_cnt, bus.spurious_cnt}, 0);
        reset_dut();

        // Interleaved routing and ignored writes
        for (int i = 0; i < 14; i++) begin
            step(tbl[i].rv, tbl[i].w, tbl[i].s, tbl[i].av, tbl[i].d, 0);
            chk($sformatf("vec%0d int_valid", i),  bus.int_resp_valid, tbl[i].iv);
            chk($sformatf("vec%0d int_data", i),   bus.int_resp_data,  tbl[i].id);
            chk($sformatf("vec%0d host_valid", i), bus.host_resp_valid, tbl[i].hv);
            chk($sformatf("vec%0d host_data", i),  bus.host_resp_data,  tbl[i].hd);
            chk($sformatf("vec%0d outstanding", i), bus.outstanding, tbl[i].out);
            chk($sformatf("vec%0d spurious_cnt", i), bus.spurious_cnt, tbl[i].sc);
        end

        // Timeout followed by a late response
        reset_dut();
        step(1, 0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        k = -1; hd = '0;
        for (int i = 2; i <= 20; i++) begin
            step(0, 0, 0, 0, 0, 0);
            if (bus.host_resp_valid) begin k = i; hd = bus.host_resp_data; break; end
        end
        chk("tmo latency", k, 9);
        chk("tmo data", hd, ERR);
        chk("tmo timeout_cnt", bus.timeout_cnt, 1);
        step(0, 0, 0, 1, 64'hAA, 0);
        chk("late A int_valid", bus.int_resp_valid, 0);
        chk("late A host_valid", bus.host_resp_valid, 0);
        chk("late A outstanding", bus.outstanding, 1);
        step(0, 0, 0, 1, 64'hBB, 0);
        chk("B int_valid", bus.int_resp_valid, 1);
        chk("B int_data", bus.int_resp_data, 64'hBB);
        chk("B host_valid", bus.host_resp_valid, 0);
        chk("B outstanding", bus.outstanding, 0);
        chk("B spurious_cnt", bus.spurious_cnt, 0);

        // Overflow, then push+pop while full
        reset_dut();
        for (int i = 0; i < 5; i++) step(1, 0, i[0], 0, 0, 0);
        chk("ovf flag", bus.err_overflow, 1);
        chk("ovf outstanding", bus.outstanding, 4);
        step(0, 0, 0, 0, 0, 1);
        chk("ovf cleared", bus.err_overflow, 0);
        step(1, 0, 1, 1, 64'h55, 0);
        chk("full push+pop overflow", bus.err_overflow, 0);
        chk("full push+pop outstanding", bus.outstanding, 4);
        chk("full push+pop int_valid", bus.int_resp_valid, 1);
        chk("full push+pop int_data", bus.int_resp_data, 64'h55);

        // Response exactly at timer == TIMEOUT, then clear vs spurious
        reset_dut();
        step(1, 0, 0, 0, 0, 0);
        seen = 0;
        for (int i = 1; i <= 8; i++) begin
            step(0, 0, 0, 0, 0, 0);
            if (bus.int_resp_valid || bus.host_resp_valid) seen = 1;
        end
        chk("boundary no early valid", seen, 0);
        step(0, 0, 0, 1, 64'h77, 0);
        chk("boundary int_valid", bus.int_resp_valid, 1);
        chk("boundary int_data", bus.int_resp_data, 64'h77);
        chk("boundary outstanding", bus.outstanding, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("boundary timeout_cnt", bus.timeout_cnt, 0);
        chk("boundary no late valid", bus.int_resp_valid | bus.host_resp_valid, 0);
        step(0, 0, 0, 1, 64'h1, 0);
        chk("spurious counted", bus.spurious_cnt, 1);
        step(0, 0, 0, 1, 64'h2, 1);
        chk("clr beats spurious", bus.spurious_cnt, 0);

        // Asynchronous reset mid-stream
        reset_dut();
        step(0, 0, 0, 1, 64'h3, 0);
        for (int i = 0; i < 4; i++) step(1, 0, i[0], 0, 0, 0);
        step(0, 0, 0, 1, 64'h99, 0);
        chk("pre-reset int_valid", bus.int_resp_valid, 1);
        chk("pre-reset outstanding", bus.outstanding, 3);
        chk("pre-reset spurious_cnt", bus.spurious_cnt, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("async rst int_valid", bus.int_resp_valid, 0);
        chk("async rst host_valid", bus.host_resp_valid, 0);
        chk("async rst int_data", bus.int_resp_data, 0);
        chk("async rst outstanding", bus.outstanding, 0);
        chk("async rst status", {bus.err_overflow, bus.timeout_cnt, bus.spurious_cnt}, 0);
        drive(0, 0, 0, 0, '0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 0, 1, 64'h11, 0);
        chk("post-reset no valid", bus.int_resp_valid | bus.host_resp_valid, 0);
        chk("post-reset spurious_cnt", bus.spurious_cnt, 1);

        // Randomized run against the reference model
        reset_dut();
        model_reset();
        mdl_on = 1;
        for (int i = 0; i < 800; i++) begin
            bit rv, w, s, av, clr;
            int av_pct;
            av_pct = ((i / 60) % 2 == 0) ? 45 : 8;
            rv  = ($urandom_range(99) < 50);
            w   = ($urandom_range(99) < 25);
            s   = 1'($urandom_range(1));
            av  = ($urandom_range(99) < av_pct);
            clr = ($urandom_range(99) < 3);
            step(rv, w, s, av, {$urandom, $urandom}, clr);
        end
        mdl_on = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/softreg_resp_router.md
# softreg_resp_router

- Routes soft-register read responses from the application back to whichever source issued the read: AOS-internal or AOS-host.
- Sits directly downstream of the soft-register request combiner and alongside the application.
  - It observes each request the combiner forwards to the app, together with the source it was granted from.
  - It records the origin of every read in an in-order tag FIFO.
  - It demultiplexes the app's in-order responses onto per-source response ports.
- Detects lost responses (timeout), spurious responses and tag-FIFO overflow. The soft-register path has no backpressure, so these are reported, not prevented.

## Interface
Parameters:
- LOG_DEPTH, 6: tag FIFO holds 2^LOG_DEPTH outstanding reads.
- DATA_W, 64: soft-register data width.
- TIMEOUT, 1024: cycles the oldest outstanding read may wait before an error response is synthesized; must be ≥2.
- ERR_DATA, 64'hDEAD_BEEF_DEAD_BEEF: data returned on a synthesized timeout response.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - clk  in  1  user clock.
  - rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  combiner is presenting a request to the app this cycle.
- req_isWrite  in  1  presented request is a write (no response expected).
- req_src  in  1  granted source: 0 = internal, 1 = host.
- app_resp_valid  in  1  app response valid.
- app_resp_data  in  DATA_W  app response data.
- int_resp_valid / int_resp_data  out  1 / DATA_W  response to AOS-internal.
- host_resp_valid / host_resp_data  out  1 / DATA_W  response to AOS-host.
- outstanding  out  LOG_DEPTH+1  reads currently tracked in the FIFO.
- err_overflow  out  1  sticky: a read tag was dropped because the FIFO was full.
- timeout_cnt  out  16  synthesized timeout responses, saturating.
- spurious_cnt  out  16  app responses with no matching read, saturating.
- err_clr  in  1  clears err_overflow, timeout_cnt and spurious_cnt.

## Operation
- Push: req_valid && !req_isWrite pushes req_src into the tag FIFO. Writes are ignored.
- Push while full:
  - If no pop occurs the same cycle, the tag is dropped and err_overflow is set.
  - If a pop occurs the same cycle, the push succeeds.
- skip_cnt (internal, LOG_DEPTH+1 bits, saturating) counts late responses still owed by timed-out reads.
- On app_resp_valid, evaluated in priority order:
  1. skip_cnt > 0: discard the response, decrement skip_cnt, no pop.
  2. Otherwise, FIFO non-empty: pop the head tag. Drive the tag's port valid with app_resp_data on the next cycle.
  3. Otherwise: discard the response and increment spurious_cnt.
- Head timer (internal, clog2(TIMEOUT+1) bits):
  - Clears on reset, on every pop, and while the FIFO is empty.
  - Otherwise increments each cycle.
- Timeout fires when the timer equals TIMEOUT and no pop happens this cycle. On timeout:
  - pop the head;
  - drive ERR_DATA to the head's port on the next cycle;
  - increment timeout_cnt and skip_cnt.
- A real pop and a timeout never fire in the same cycle; the response wins.
- Only one response port is valid in any cycle. Data on the invalid port is driven to 0.
- err_clr takes priority over a same-cycle increment or set of the status outputs. It does not affect the FIFO or skip_cnt.
- An asynchronous reset mid-operation:
  - empties the FIFO;
  - zeroes skip_cnt, the timer, the counters and err_overflow;
  - deasserts both valids immediately.
  - In-flight tags are lost by design.

## Timing
- Every output is registered. Reset value of every output is 0.
- Latency from app_resp_valid to int/host_resp_valid is exactly 1 cycle.
- Sustains one response per cycle; back-to-back responses produce back-to-back valids.
- A read pushed in cycle N can be matched by a response in cycle N+1, but not in cycle N. A response in the same cycle as the push of the FIFO's only entry counts as spurious.
- outstanding reflects pushes and pops of the previous cycle.
- Timeout:
  - The response valid is asserted TIMEOUT+1 cycles after the cycle in which the read became head. This assumes no response arrives.
  - A response arriving in the cycle the timer equals TIMEOUT is routed normally, and no timeout is recorded.
- Counters saturate at 16'hFFFF. skip_cnt saturates at 2^(LOG_DEPTH+1)-1.
- Pointer wrap-around is modulo 2^LOG_DEPTH. Full/empty are distinguished by the extra pointer bit.

## Test plan
- Interleaved routing:
  - Stimulus: reads src=0,1,1,0 on consecutive cycles, then 4 app responses with data 1..4.
  - Required: int gets 1 and 4, host gets 2 and 3, each one cycle after its response; outstanding returns to 0.
- Writes ignored:
  - Stimulus: 3 writes from host, then 1 app response.
  - Required: no valid on either port; spurious_cnt=1.
- Timeout then late response (TIMEOUT=8):
  - Stimulus: host read with no response, then an int read, then two responses A and B.
  - Required:
    - host_resp_data=ERR_DATA 9 cycles after the host read becomes head; timeout_cnt=1;
    - A is discarded;
    - B goes to int.
- Overflow (LOG_DEPTH=2):
  - Stimulus: 5 reads, no responses.
  - Required: err_overflow=1, outstanding=4.
  - Follow-up: a push plus a response in the same cycle while full → no new overflow event; outstanding stays 4.
- Boundary/clear:
  - Stimulus: a response arrives exactly when timer=TIMEOUT.
  - Required: routed normally, timeout_cnt unchanged.
  - Follow-up: err_clr in the same cycle as a spurious response → spurious_cnt=0.
- Reset mid-stream:
  - Stimulus: assert rst_n low with 3 reads outstanding and a valid being driven.
  - Required: valids drop immediately and all status is 0; the first post-reset response counts as spurious.
